// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: serial UART receiver feeding a first-word-fall-through byte FIFO
// Ports: clk, rst_n (synchronous, active-low); uart_rx_i asynchronous serial line (idle high, LSB first);
//   rx_data_o/rx_valid_o/rx_ready_i FWFT pop port; rx_count_o occupancy;
//   frame_err_o/overrun_o/parity_err_o sticky flags, cleared by the err_clr_i pulse.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking; otherwise 8N1 and parity_err_o is 0.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUDRATE   = 1152000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          parity_err_o,
  input  logic                          err_clr_i
);
  localparam int CPB  = CLK_FREQ / BAUDRATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif
  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d, warm_q, warm_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          ferr_q, ferr_d, ovr_q, ovr_d;
  logic          rxs, bit_end, half_bit, push, ferr_set, pop, full, wr_en;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d, perr_set;
`endif
  assign rxs      = sync_q[1];
  assign bit_end  = cnt_q == CW'(CPB - 1);
  assign half_bit = cnt_q == CW'(HALF - 1);
  // A frame may only start once the synchroniser has delivered a genuine high
  // after reset, so a reset landing inside a low bit cannot start a bogus frame.
  always_comb begin
    sync_d  = {sync_q[0], uart_rx_i};
    warm_d  = {warm_q[0], 1'b1};
    armed_d = armed_q | (warm_q[1] & rxs);
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = (armed_q && !rxs) ? S_START : S_IDLE;
      end
      S_START: if (half_bit) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (bit_end) begin
        cnt_d   = '0;
        shift_d = {rxs, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? AFTER_DATA : S_DATA;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (bit_end) begin
        cnt_d    = '0;
        perr_set = rxs ^ (^shift_q);
        state_d  = S_STOP;
      end
`endif
      S_STOP: if (bit_end) begin
        cnt_d    = '0;
        push     = rxs;
        ferr_set = !rxs;
        state_d  = rxs ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        cnt_d   = '0;
        state_d = rxs ? S_IDLE : S_WAIT_HIGH;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end
  assign rx_data_o  = mem_q[rd_q];
  assign rx_valid_o = count_q != '0;
  assign rx_count_o = count_q;
  assign pop        = rx_valid_o & rx_ready_i;
  assign full       = count_q == (AW + 1)'(FIFO_DEPTH);
  assign wr_en      = push & (~full | pop);
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = shift_q;
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    ferr_d  = ferr_set | (ferr_q & ~err_clr_i);
    ovr_d   = (push & full & ~pop) | (ovr_q & ~err_clr_i);
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_set | (perr_q & ~err_clr_i);
`endif
  end
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      warm_q  <= 2'b00;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      mem_q   <= '{default: 8'h00};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      warm_q  <= warm_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end
endmodule
